// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types and constants for the mem_responder slice
package mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10,
      HOLD   = 2'b11
   } state_t;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_responder_array.sv
// rtl/mem_responder_array.sv - small storage array, sync write, comb read
// Optional clear-on-reset: MEM_RESPONDER_CLEAR_EN
module mem_responder_array #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

`ifdef MEM_RESPONDER_CLEAR_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**ADDR_W; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[addr] <= wdata;
      end
   end
`else
   // Contents survive reset, but a write landing on a reset cycle is dropped.
   always_ff @(posedge clk) begin
      if (we && !rst) begin
         mem[addr] <= wdata;
      end
   end
`endif

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency valid/rw responder with done pulse
// Optional array clear on reset: MEM_RESPONDER_CLEAR_EN
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W      = 2,
   parameter int DATA_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata
);

   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("mem_responder: WAIT_CYCLES must be in 1..15");
   end

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic                rw_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   mem_rdata;
   logic                fire;
   logic                mem_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         rw_q    <= RW_READ;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_nxt;
         // Request fields are captured once; later input churn is ignored.
         if (state == IDLE && valid) begin
            rw_q    <= rw;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= CNT_W'(WAIT_CYCLES - 1);
         end else if (state == ACCESS && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (fire && rw_q == RW_READ) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      fire      = 1'b0;
      busy      = (state != IDLE);
      done      = (state == DONE);
      case (state)
         IDLE:   if (valid) state_nxt = ACCESS;
         ACCESS: if (cnt == '0) begin
                    fire      = 1'b1;
                    state_nxt = DONE;
                 end
         DONE:   state_nxt = valid ? HOLD : IDLE;
         HOLD:   if (!valid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign mem_we = fire && (rw_q == RW_WRITE);
   assign rdata  = rdata_q;

   mem_responder_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
module tb_mem_responder;

   localparam int WAIT = 2;

   typedef struct {
      logic [7:0] exp_rdata;
      int         accept_cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic       rw = 1'b0;
   logic [1:0] addr = '0;
   logic [7:0] wdata = '0;
   logic       busy, done;
   logic [7:0] rdata;

   int   checks = 0;
   int   errs = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   exp_t sb[$];
   logic [7:0] mem_m [4];
   logic [7:0] last_rd = 8'h00;

   mem_responder #(.ADDR_W(2), .DATA_W(8), .WAIT_CYCLES(WAIT)) dut (
      .clk   (clk),
      .rst   (rst),
      .valid (valid),
      .rw    (rw),
      .addr  (addr),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .rdata (rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push_expect(input logic w, input logic [1:0] a, input logic [7:0] d);
      exp_t e;
      if (w) mem_m[a] = d;
      else   last_rd = mem_m[a];
      e.exp_rdata  = last_rd;
      e.accept_cyc = cyc + 1;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (!rst && done === 1'b1) begin
         exp_t e;
         done_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            check("rdata_at_done", rdata, e.exp_rdata);
            check("done_latency", cyc - e.accept_cyc, WAIT);
         end
      end
   end

   task automatic access(input logic w, input logic [1:0] a, input logic [7:0] d,
                         input int hold, input bit churn);
      int start;
      int t;
      push_expect(w, a, d);
      start = done_cnt;
      valid = 1'b1; rw = w; addr = a; wdata = d;
      repeat (hold) step();
      valid = 1'b0;
      if (churn) begin
         addr  = 2'd0;
         wdata = 8'hFF;
         rw    = ~w;
      end
      t = 0;
      while (done_cnt == start && t < 20) begin
         step();
         t++;
      end
      check("done_seen", done_cnt - start, 1);
      while (busy && t < 40) begin
         step();
         t++;
      end
      check("idle_after", busy, 0);
      step();
   endtask

   initial begin
      int start;

      // Reset then idle
      repeat (3) step();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("idle_busy", busy, 0);
         check("idle_done", done, 0);
         check("idle_rdata", rdata, 8'h00);
      end

      // Write/read, including rdata unchanged by writes
      access(1'b1, 2'd0, 8'h11, 1, 1'b0);
      access(1'b1, 2'd2, 8'hA5, 1, 1'b0);
      access(1'b0, 2'd2, 8'h00, 1, 1'b0);
      access(1'b1, 2'd1, 8'h5A, 1, 1'b0);
      check("write_keeps_rdata", rdata, 8'hA5);

      // Held valid: single done, busy until valid drops
      push_expect(1'b0, 2'd1, 8'h00);
      start = done_cnt;
      valid = 1'b1; rw = 1'b0; addr = 2'd1;
      repeat (12) step();
      check("held_busy", busy, 1);
      valid = 1'b0;
      step();
      check("held_release_busy", busy, 0);
      check("held_one_done", done_cnt - start, 1);
      step();

      // Input churn during ACCESS
      access(1'b1, 2'd3, 8'h3C, 1, 1'b1);
      access(1'b0, 2'd3, 8'h00, 1, 1'b0);
      access(1'b0, 2'd0, 8'h00, 1, 1'b0);

      // Reset in the ACCESS cycle of a write
      start = done_cnt;
      valid = 1'b1; rw = 1'b1; addr = 2'd0; wdata = 8'h77;
      step();
      rst = 1'b1;
      valid = 1'b0;
      step();
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_rdata", rdata, 8'h00);
      last_rd = 8'h00;
`ifdef MEM_RESPONDER_CLEAR_EN
      for (int i = 0; i < 4; i++) mem_m[i] = 8'h00;
`endif
      rst = 1'b0;
      access(1'b0, 2'd0, 8'h00, 1, 1'b0);
      check("rst_no_done", done_cnt - start, 1);

`ifdef MEM_RESPONDER_CLEAR_EN
      for (int i = 0; i < 4; i++) access(1'b1, 2'(i), 8'(8'hC0 + i), 1, 1'b0);
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      last_rd = 8'h00;
      for (int i = 0; i < 4; i++) mem_m[i] = 8'h00;
      for (int i = 0; i < 4; i++) access(1'b0, 2'(i), 8'h00, 1, 1'b0);
`endif

      repeat (4) step();
      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
